// File: rtl/stopwatch_disp_pkg.sv
// Shared constants and segment decoding for the stopwatch display.
// Latency: n/a (package; the decode function is purely combinational).
// Backpressure: n/a.
// Segment vectors are {g,f,e,d,c,b,a} and active-low throughout.
package stopwatch_disp_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Returns the active-low pattern for digits 0-9. Any other code shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/stopwatch_display_bin2bcd.sv
// 6-bit binary to two BCD digits, using compare/subtract steps only.
// Latency: combinational, 0 cycles.
// Backpressure: none.
// Ports: bin (0..63) -> tens, ones, and valid (high when bin <= 59).
module bin2bcd_6b (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       valid
);

    logic       t40;
    logic       t20;
    logic       t10;
    logic [5:0] r40;
    logic [5:0] r20;

    // Peel off 40, then 20, then 10. For 0..63 the tens digit is at most 6,
    // so these three weighted bits form it directly.
    assign t40 = (bin >= 6'd40);
    assign r40 = t40 ? (bin - 6'd40) : bin;
    assign t20 = (r40 >= 6'd20);
    assign r20 = t20 ? (r40 - 6'd20) : r40;
    assign t10 = (r20 >= 6'd10);

    assign tens  = {1'b0, t40, t20, t10};
    assign ones  = t10 ? 4'(r20 - 6'd10) : r20[3:0];
    assign valid = (bin <= 6'd59);

endmodule

// File: rtl/stopwatch_display.sv
// Six-digit, time-multiplexed, common-anode HH.MM.SS display driver. The time is snapshotted once per scan frame.
// Latency: outputs are registered one stage behind the scan counters; a snapshot reaches digit 0 one cycle after the frame boundary.
// Backpressure: none. blank forces the outputs off without disturbing the scan phase.
// Ports: clk, rst (sync, active-high), sec/min/hour (binary) and blank in; an (active-low enables), seg, dp (active-low) out.
module stopwatch_display
    import stopwatch_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LEAD  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            sec,
    input  logic [5:0]            min,
    input  logic [3:0]            hour,
    input  logic                  blank,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int               DIV_W    = $clog2(REFRESH_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [2:0]       idx;
    logic [5:0]       snap_sec;
    logic [5:0]       snap_min;
    logic [3:0]       snap_hour;

    logic [3:0] sec_tens,  sec_ones;
    logic [3:0] min_tens,  min_ones;
    logic [3:0] hour_tens, hour_ones;
    logic       sec_ok, min_ok, hour_ok;

    bin2bcd_6b u_bcd_sec (
        .bin   (snap_sec),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .valid (sec_ok)
    );

    bin2bcd_6b u_bcd_min (
        .bin   (snap_min),
        .tens  (min_tens),
        .ones  (min_ones),
        .valid (min_ok)
    );

    // Hours are 0..15, so this instance always reports valid.
    bin2bcd_6b u_bcd_hour (
        .bin   ({2'b00, snap_hour}),
        .tens  (hour_tens),
        .ones  (hour_ones),
        .valid (hour_ok)
    );

    logic [6:0]            digit_seg;
    logic [NUM_DIGITS-1:0] digit_an;
    logic                  digit_dp;

    // The pattern for the digit currently selected by the pre-edge idx.
    always_comb begin
        digit_seg = SEG_BLANK;
        case (idx)
            3'd0: digit_seg = sec_ok  ? seg_decode(sec_ones)  : SEG_DASH;
            3'd1: digit_seg = sec_ok  ? seg_decode(sec_tens)  : SEG_DASH;
            3'd2: digit_seg = min_ok  ? seg_decode(min_ones)  : SEG_DASH;
            3'd3: digit_seg = min_ok  ? seg_decode(min_tens)  : SEG_DASH;
            3'd4: digit_seg = hour_ok ? seg_decode(hour_ones) : SEG_DASH;
            3'd5: begin
                // A leading hour zero goes dark but keeps its anode enabled.
                if (BLANK_LEAD && (hour_tens == 4'd0))
                    digit_seg = SEG_BLANK;
                else
                    digit_seg = hour_ok ? seg_decode(hour_tens) : SEG_DASH;
            end
            default: digit_seg = SEG_BLANK;
        endcase
    end

    assign digit_an = ~(NUM_DIGITS'(1) << idx);
    // Separators follow the hours and minutes fields.
    assign digit_dp = !((idx == 3'd2) || (idx == 3'd4));

    always_ff @(posedge clk) begin
        if (rst) begin
            div       <= '0;
            idx       <= 3'd0;
            snap_sec  <= 6'd0;
            snap_min  <= 6'd0;
            snap_hour <= 4'd0;
            an        <= '1;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
        end else begin
            if (div == DIV_LAST) begin
                div <= '0;
                if (idx == 3'd5) begin
                    // Frame boundary: the only edge that samples the time.
                    idx       <= 3'd0;
                    snap_sec  <= sec;
                    snap_min  <= min;
                    snap_hour <= hour;
                end else begin
                    idx <= idx + 3'd1;
                end
            end else begin
                div <= div + DIV_W'(1);
            end

            // Blanking touches only the outputs, so the scan phase survives it.
            if (blank) begin
                an  <= '1;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else begin
                an  <= digit_an;
                seg <= digit_seg;
                dp  <= digit_dp;
            end
        end
    end

endmodule
